// File: rtl/lfsr_seg_pkg.sv
// Shared constants for the LFSR stepper: tap/seed defaults, FSM encodings and
// the hex 7-segment decode (bit0=a .. bit6=g, active-high).
package lfsr_seg_pkg;

  localparam logic [7:0] TAPS_DEFAULT       = 8'hB8;
  localparam logic [7:0] RESET_SEED_DEFAULT = 8'h01;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a one-cycle rising-edge
// pulse taken from the synchronized level against a third delay stage.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes this a shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/lfsr_seg_stepper.sv
// Maximal-length Fibonacci LFSR advanced free-running at a divided rate or by
// single steps, with a registered hex 7-segment view of the low nibble.
module lfsr_seg_stepper
  import lfsr_seg_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = TAPS_DEFAULT,
  parameter int               DIV_MAX    = 10_000_000,
  parameter logic [WIDTH-1:0] RESET_SEED = RESET_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  output logic [WIDTH-1:0] lfsr_out,
  output logic [6:0]       segments,
  output logic             dp,
  output logic             running
);

  localparam int PW = $clog2(DIV_MAX);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_MAX - 1);

  logic load_level, load_rise;
  logic step_level, step_rise;
  logic run_level, run_rise;
  logic unused_levels;

  sync_edge u_load (.clk(clk), .rst(rst), .pin(load), .level(load_level), .rise(load_rise));
  sync_edge u_step (.clk(clk), .rst(rst), .pin(step), .level(step_level), .rise(step_rise));
  sync_edge u_run  (.clk(clk), .rst(rst), .pin(run),  .level(run_level),  .rise(run_rise));

  assign unused_levels = ^{load_level, step_level, run_rise};

  logic [WIDTH-1:0] lfsr, lfsr_next;
  logic             dp_next;
  state_t           state, state_next;
  logic [PW-1:0]    presc, presc_next;
  logic             advance;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    lfsr_next  = lfsr;
    dp_next    = dp;
    state_next = state;
    presc_next = presc;
    advance    = 1'b0;

    if (ena) begin
      // A load edge owns the cycle: it suppresses any advance and state change.
      if (load_rise) begin
        lfsr_next  = (seed_in == '0) ? RESET_SEED : seed_in;
        presc_next = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (run_level) begin
              state_next = ST_RUN;
              presc_next = '0;
            end else if (step_rise) begin
              advance    = 1'b1;
              state_next = ST_PAUSE;
            end
          end
          ST_RUN: begin
            if (!run_level) begin
              state_next = ST_PAUSE;
              presc_next = '0;
            end else if (presc == PRESC_LAST) begin
              advance    = 1'b1;
              presc_next = '0;
            end else begin
              presc_next = presc + 1'b1;
            end
          end
          ST_PAUSE: begin
            if (run_level) begin
              state_next = ST_RUN;
              presc_next = '0;
            end else if (step_rise) begin
              advance = 1'b1;
            end
          end
          default: state_next = ST_IDLE;
        endcase

        if (advance) begin
          lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
          dp_next   = ~dp;
        end
      end
    end
  end

  // Segments are decoded from the next LFSR value so they line up with lfsr_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= RESET_SEED;
      dp       <= 1'b0;
      state    <= ST_IDLE;
      presc    <= '0;
      segments <= seg_decode(RESET_SEED[3:0]);
    end else begin
      lfsr     <= lfsr_next;
      dp       <= dp_next;
      state    <= state_next;
      presc    <= presc_next;
      segments <= seg_decode(lfsr_next[3:0]);
    end
  end

  assign lfsr_out = lfsr;
  assign running  = (state == ST_RUN);

endmodule

// File: tb/tb_lfsr_seg_stepper.sv
// Bench for lfsr_seg_stepper: directed vector table, multi-cycle corner cases
// and a randomized phase checked against a sequence-index reference model.
module tb_lfsr_seg_stepper;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] seed_in = 8'h00;
  logic       load = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [7:0] lfsr_out;
  logic [6:0] segments;
  logic       dp;
  logic       running;

  lfsr_seg_stepper #(
    .WIDTH(8), .TAPS(8'hB8), .DIV_MAX(DIV), .RESET_SEED(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .seed_in(seed_in), .load(load),
    .run(run), .step(step), .lfsr_out(lfsr_out), .segments(segments),
    .dp(dp), .running(running)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // The whole period as a list: an advance is just "next index".
  logic [7:0] seq [255];

  function automatic logic [7:0] poly_next(input logic [7:0] v);
    int fb;
    fb = $countones(v & 8'hB8) % 2;
    return 8'((int'(v) * 2) % 256 + fb);
  endfunction

  function automatic int index_of(input logic [7:0] v);
    for (int i = 0; i < 255; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  // Reference model: pins seen through a 3-deep history, LFSR as an index.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mode_t;
  typedef struct {
    mode_t  mode;
    int     idx;
    int     cnt;
    bit     dp;
    bit [2:0] h_load;
    bit [2:0] h_run;
    bit [2:0] h_step;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t c, input logic en, input logic ld,
                                        input logic rn, input logic st, input logic [7:0] sd);
    model_t n;
    bit run_s, load_e, step_e, adv;
    n      = c;
    run_s  = c.h_run[1];
    load_e = c.h_load[1] && !c.h_load[2];
    step_e = c.h_step[1] && !c.h_step[2];
    adv    = 1'b0;
    if (en) begin
      if (load_e) begin
        n.idx = index_of((sd == 8'h00) ? 8'h01 : sd);
        n.cnt = 0;
      end else if (c.mode == M_IDLE) begin
        if (run_s) begin n.mode = M_RUN; n.cnt = 0; end
        else if (step_e) begin adv = 1'b1; n.mode = M_PAUSE; end
      end else if (c.mode == M_RUN) begin
        if (!run_s) begin n.mode = M_PAUSE; n.cnt = 0; end
        else if (c.cnt == DIV - 1) begin adv = 1'b1; n.cnt = 0; end
        else n.cnt = c.cnt + 1;
      end else begin
        if (run_s) begin n.mode = M_RUN; n.cnt = 0; end
        else if (step_e) adv = 1'b1;
      end
      if (adv) begin
        n.idx = (c.idx + 1) % 255;
        n.dp  = !c.dp;
      end
    end
    n.h_load = {c.h_load[1:0], ld};
    n.h_run  = {c.h_run[1:0], rn};
    n.h_step = {c.h_step[1:0], st};
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{M_IDLE, 0, 0, 1'b0, 3'b0, 3'b0, 3'b0};
    else     m <= model_next(m, ena, load, run, step, seed_in);
  end

  task automatic pulse_step();
    @(negedge clk); step = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [7:0] sd);
    @(negedge clk); seed_in = sd; load = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_change(input logic [7:0] from, input int budget, output int waited);
    waited = 0;
    while (lfsr_out === from && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] e_lfsr, input logic e_dp,
                           input logic e_run);
    check({name, ".lfsr"}, lfsr_out, e_lfsr);
    check({name, ".seg"}, segments, seg_ref[e_lfsr[3:0]]);
    check({name, ".dp"}, dp, e_dp);
    check({name, ".running"}, running, e_run);
  endtask

  typedef enum {OP_STEP, OP_LOAD} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] seed;
    logic [7:0] e_lfsr;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_run;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int         w;
    int         zeros, dups, mism;
    logic [7:0] last, v;
    logic [7:0] got [6];
    logic [7:0] run_exp [6];
    bit         seen [256];
    logic [7:0] vv;
    int         ii;

    seq[0] = 8'h01;
    for (int i = 1; i < 255; i++) seq[i] = poly_next(seq[i-1]);

    vecs[0] = '{OP_STEP, 8'h00, 8'h02, 7'h5B, 1'b1, 1'b0};
    vecs[1] = '{OP_STEP, 8'h00, 8'h04, 7'h66, 1'b0, 1'b0};
    vecs[2] = '{OP_STEP, 8'h00, 8'h08, 7'h7F, 1'b1, 1'b0};
    vecs[3] = '{OP_STEP, 8'h00, 8'h11, 7'h06, 1'b0, 1'b0};
    vecs[4] = '{OP_LOAD, 8'h00, 8'h01, 7'h06, 1'b0, 1'b0};
    vecs[5] = '{OP_LOAD, 8'hA5, 8'hA5, 7'h6D, 1'b0, 1'b0};
    vecs[6] = '{OP_STEP, 8'h00, 8'h4A, 7'h77, 1'b1, 1'b0};
    vecs[7] = '{OP_LOAD, 8'h3C, 8'h3C, 7'h39, 1'b1, 1'b0};
    run_exp = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};

    // Reset state, then held with idle pins.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all("reset", 8'h01, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check_all("reset_hold", 8'h01, 1'b0, 1'b0);

    // Vector table: single steps and loads from the paused state.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].op == OP_STEP) pulse_step();
      else pulse_load(vecs[i].seed);
      check($sformatf("vec%0d.lfsr", i), lfsr_out, vecs[i].e_lfsr);
      check($sformatf("vec%0d.seg", i), segments, vecs[i].e_seg);
      check($sformatf("vec%0d.dp", i), dp, vecs[i].e_dp);
      check($sformatf("vec%0d.running", i), running, vecs[i].e_run);
    end

    // Free-run from the reset seed: one advance every DIV clocks.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); run = 1'b1;
    last = 8'h01;
    for (int k = 0; k < 6; k++) begin
      wait_change(last, 20, w);
      got[k] = lfsr_out;
      check($sformatf("run%0d.lfsr", k), got[k], run_exp[k]);
      if (k > 0) check($sformatf("run%0d.gap", k), w, DIV);
      last = got[k];
    end
    check("run.running", running, 1'b1);
    run = 1'b0;
    repeat (12) @(negedge clk);
    check("pause.running", running, 1'b0);
    check("pause.hold", lfsr_out, 8'h47);

    // Load edge landing on the same cycle as a prescaler wrap.
    run = 1'b1;
    wait_change(8'h47, 20, w);
    @(posedge clk);
    @(negedge clk); seed_in = 8'hA5; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (2) @(negedge clk);
    check("ldwrap.lfsr", lfsr_out, 8'hA5);
    check("ldwrap.seg", segments, 7'h6D);
    repeat (3) @(negedge clk);
    check("ldwrap.restart", lfsr_out, 8'hA5);
    @(negedge clk);
    check("ldwrap.next", lfsr_out, 8'h4A);

    // Full period from seed 01 while running.
    pulse_load(8'h01);
    check("period.start", lfsr_out, 8'h01);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    zeros = 0; dups = 0; mism = 0;
    last = 8'h01;
    for (int i = 1; i <= 255; i++) begin
      wait_change(last, 8, w);
      v = lfsr_out;
      if (v == 8'h00) zeros++;
      if (i < 255 && seen[v]) dups++;
      if (v != seq[i % 255]) mism++;
      seen[v] = 1'b1;
      last = v;
    end
    run = 1'b0;
    check("period.zeros", zeros, 0);
    check("period.dups", dups, 0);
    check("period.seq", mism, 0);
    check("period.wrap", last, 8'h01);
    repeat (6) @(negedge clk);
    check("period.hold", lfsr_out, 8'h01);
    check("period.running", running, 1'b0);

    // Step edges while deselected are dropped, not queued.
    @(negedge clk); ena = 1'b0;
    pulse_step();
    repeat (2) @(negedge clk);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    check("ena0.lfsr", lfsr_out, 8'h01);
    pulse_step();
    check("ena1.lfsr", lfsr_out, 8'h02);
    check("ena1.seg", segments, 7'h5B);

    // Asynchronous reset between clock edges while running.
    @(negedge clk); run = 1'b1;
    repeat (12) @(negedge clk);
    check("arst.pre_running", running, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all("arst", 8'h01, 1'b0, 1'b0);
    @(negedge clk); run = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Randomized pins against the reference model.
    repeat (2) @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ii = m.idx;
      vv = seq[ii];
      check("rand", {lfsr_out, segments, dp, running},
            {vv, seg_ref[vv[3:0]], m.dp, (m.mode == M_RUN)});
      if ($urandom_range(0, 11) == 0) load = ~load;
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 5) == 0) step = ~step;
      ena = ($urandom_range(0, 15) != 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
